// File: rtl/calc2_pkg.sv
// Shared types for the calc2 port driver: command/response encodings,
// per-tag lifecycle state, issue FSM states and the queued result record.
// No logic; imported by calc2_resp_fifo and calc2_port_driver.
package calc2_pkg;

    localparam int NTAGS = 4;

    // calc2 command encodings (other values are passed through untouched)
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    // calc2 response encodings; TIMEOUT is produced locally, never by calc2
    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_ERR     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        TAG_FREE,
        TAG_ISSUED,
        TAG_DONE
    } tag_state_t;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_SEND1,
        ISS_SEND2
    } issue_state_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } result_t;

endpackage

// File: rtl/calc2_resp_fifo.sv
// 4-entry result_t FIFO with single push / single pop per cycle.
// Latency: a push is visible at pop_dat the cycle after the push edge.
// Backpressure: push is ignored when full, pop ignored when empty (full/empty flags exposed).
// Ports: c_clk, reset (async, active-high), push/push_dat, pop/pop_dat, full, empty.
module calc2_resp_fifo
    import calc2_pkg::*;
(
    input  logic    c_clk,
    input  logic    reset,
    input  logic    push,
    input  result_t push_dat,
    input  logic    pop,
    output result_t pop_dat,
    output logic    full,
    output logic    empty
);

    result_t    mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 3'd4);
    assign empty   = (count == 3'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while count > 0.
    always_ff @(posedge c_clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/calc2_port_driver.sv
// Request engine for one calc2 port: serialises ops into the 2-cycle calc2 request,
// tracks 4 tags, queues responses/timeouts. Latency: op1 on req_* 1 edge after accept,
// op2 one edge later; result 1 edge after response. Backpressure: op_ready drops in SEND1
// or when no tag is FREE; results held in a 4-entry queue until res_ready.
// Ports: op_* (offer side), req_*_out (to calc2), resp_*_in (from calc2),
//        res_* (result side), outstanding (non-FREE tag count), spurious_err (1-cycle pulse).
module calc2_port_driver
    import calc2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [1:0]  op_tag,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    output logic [1:0]  req_tag_out,
    input  logic [1:0]  resp_in,
    input  logic [31:0] resp_data_in,
    input  logic [1:0]  resp_tag_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_resp,
    output logic [31:0] res_data,
    output logic [1:0]  res_tag,
    output logic [2:0]  outstanding,
    output logic        spurious_err
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    issue_state_t     iss_st;
    tag_state_t       tag_st  [NTAGS];
    logic [CNT_W-1:0] tmo_cnt [NTAGS];
    logic [31:0]      op2_hold;

    logic    any_free;
    logic    accept;
    logic    resp_hit;
    logic    resp_spur;
    logic    tmo_any;
    logic [1:0] tmo_tag;
    logic    push_en;
    result_t push_dat;
    logic    pop;
    result_t head;
    logic    fifo_full;
    logic    fifo_empty;

    // Lowest-index FREE tag is the one offered next.
    always_comb begin
        any_free = 1'b0;
        op_tag   = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (tag_st[i] == TAG_FREE) begin
                any_free = 1'b1;
                op_tag   = 2'(i);
            end
        end
    end

    // SEND1 is the only state that cannot take a new op: op2 of the previous
    // op is still to be driven.
    assign op_ready = !reset && (iss_st != ISS_SEND1) && any_free;
    assign accept   = op_valid && op_ready;

    assign resp_hit  = (resp_in != RESP_NONE) && (tag_st[resp_tag_in] == TAG_ISSUED);
    assign resp_spur = (resp_in != RESP_NONE) && (tag_st[resp_tag_in] != TAG_ISSUED);

    // Expired tag to report. A tag answered this very cycle is excluded so the
    // real response wins; other expired tags wait (counter is saturated).
    always_comb begin
        tmo_any = 1'b0;
        tmo_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (tag_st[i] == TAG_ISSUED && tmo_cnt[i] == CNT_MAX &&
                !(resp_hit && resp_tag_in == 2'(i))) begin
                tmo_any = 1'b1;
                tmo_tag = 2'(i);
            end
        end
    end

    always_comb begin
        push_dat = '{resp: RESP_TIMEOUT, data: 32'd0, tag: tmo_tag};
        if (resp_hit) begin
            push_dat = '{resp: resp_in, data: resp_data_in, tag: resp_tag_in};
        end
    end

    // The queue cannot actually be full when a push is wanted (one entry per
    // non-FREE tag); the guard just keeps tag state and queue in step.
    assign push_en = (resp_hit || tmo_any) && !fifo_full;
    assign pop     = res_valid && res_ready;

    calc2_resp_fifo u_fifo (
        .c_clk    (c_clk),
        .reset    (reset),
        .push     (push_en),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_resp  = fifo_empty ? 2'd0  : head.resp;
    assign res_data  = fifo_empty ? 32'd0 : head.data;
    assign res_tag   = fifo_empty ? 2'd0  : head.tag;

    // Accept, push and pop always touch different tags (FREE, ISSUED, DONE
    // respectively), so the priority order below never hides an event.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAGS; i++) begin
                tag_st[i]  <= TAG_FREE;
                tmo_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAGS; i++) begin
                if (accept && op_tag == 2'(i)) begin
                    tag_st[i]  <= TAG_ISSUED;
                    tmo_cnt[i] <= '0;
                end else if (push_en && push_dat.tag == 2'(i)) begin
                    tag_st[i] <= TAG_DONE;
                end else if (pop && head.tag == 2'(i)) begin
                    tag_st[i] <= TAG_FREE;
                end else if (tag_st[i] == TAG_ISSUED && tmo_cnt[i] != CNT_MAX) begin
                    tmo_cnt[i] <= tmo_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < NTAGS; i++) begin
            if (tag_st[i] != TAG_FREE) outstanding = outstanding + 3'd1;
        end
    end

    // Issue FSM with registered request outputs. op_b is captured at accept
    // so the offer side need not hold it into the second request cycle.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            iss_st       <= ISS_IDLE;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            req_tag_out  <= '0;
            op2_hold     <= '0;
        end else begin
            case (iss_st)
                ISS_SEND1: begin
                    iss_st       <= ISS_SEND2;
                    req_cmd_out  <= '0;
                    req_data_out <= op2_hold;
                    req_tag_out  <= '0;
                end
                default: begin
                    if (accept) begin
                        iss_st       <= ISS_SEND1;
                        req_cmd_out  <= op_cmd;
                        req_data_out <= op_a;
                        req_tag_out  <= op_tag;
                        op2_hold     <= op_b;
                    end else begin
                        iss_st       <= ISS_IDLE;
                        req_cmd_out  <= '0;
                        req_data_out <= '0;
                        req_tag_out  <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) spurious_err <= 1'b0;
        else       spurious_err <= resp_spur;
    end

endmodule

// File: tb/tb_calc2_port_driver.sv
module tb_calc2_port_driver;
    import calc2_pkg::*;

    localparam int TMO = 16;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_cmd = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [1:0]  op_tag;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  req_tag_out;
    logic [1:0]  resp_in = '0;
    logic [31:0] resp_data_in = '0;
    logic [1:0]  resp_tag_in = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic [1:0]  res_tag;
    logic [2:0]  outstanding;
    logic        spurious_err;

    int tests = 0;
    int fails = 0;

    calc2_port_driver #(.TIMEOUT_CYCLES(TMO)) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_cmd       (op_cmd),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_tag       (op_tag),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .req_tag_out  (req_tag_out),
        .resp_in      (resp_in),
        .resp_data_in (resp_data_in),
        .resp_tag_in  (resp_tag_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_resp     (res_resp),
        .res_data     (res_data),
        .res_tag      (res_tag),
        .outstanding  (outstanding),
        .spurious_err (spurious_err)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic        v;
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rsp;
        logic [31:0] rdat;
        logic [1:0]  rtag;
        logic        rrdy;
        logic        e_rdy;
        logic [1:0]  e_tag;
        logic [3:0]  e_cmd;
        logic [31:0] e_data;
        logic [1:0]  e_qtag;
        logic        e_vld;
        logic [1:0]  e_resp;
        logic [31:0] e_rdat;
        logic [1:0]  e_restag;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic v, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
        input logic [1:0] rsp, input logic [31:0] rdat, input logic [1:0] rtag, input logic rrdy,
        input logic e_rdy, input logic [1:0] e_tag,
        input logic [3:0] e_cmd, input logic [31:0] e_data, input logic [1:0] e_qtag,
        input logic e_vld, input logic [1:0] e_resp, input logic [31:0] e_rdat, input logic [1:0] e_restag,
        input logic [2:0] e_out);
        vec_t r;
        r.v = v; r.cmd = cmd; r.a = a; r.b = b;
        r.rsp = rsp; r.rdat = rdat; r.rtag = rtag; r.rrdy = rrdy;
        r.e_rdy = e_rdy; r.e_tag = e_tag;
        r.e_cmd = e_cmd; r.e_data = e_data; r.e_qtag = e_qtag;
        r.e_vld = e_vld; r.e_resp = e_resp; r.e_rdat = e_rdat; r.e_restag = e_restag;
        r.e_out = e_out;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic found;

        // ---- reset state ----
        #1 reset = 1'b1;
        #1;
        chk("reset ctl", 64'({op_ready, op_tag, outstanding, spurious_err}), 64'(0));
        chk("reset req", 64'({req_cmd_out, req_data_out, req_tag_out}), 64'(0));
        chk("reset res", 64'({res_valid, res_resp, res_data, res_tag}), 64'(0));
        @(negedge c_clk);
        reset = 1'b0;

        // ---- single ADD: request serialisation and response path ----
        //              v cmd a        b         rsp rdat      rtag rrdy  rdy tag  cmd data      qt  vld rsp rdat      rt  out
        vt.push_back(mk(1, CMD_ADD, 32'h30, 32'h20, 0, 0, 0, 0,  1, 0,  0, 0, 0,           0, 0, 0, 0,            0));
        vt.push_back(mk(0, 0, 0, 0,             0, 0, 0, 0,      0, 1,  CMD_ADD, 32'h30, 0, 0, 0, 0, 0,         1));
        vt.push_back(mk(0, 0, 0, 0,             RESP_OK, 32'h50, 0, 0, 1, 1, 0, 32'h20, 0, 0, 0, 0, 0,     1));
        vt.push_back(mk(0, 0, 0, 0,             0, 0, 0, 0,      1, 1,  0, 0, 0,           1, RESP_OK, 32'h50, 0, 1));
        vt.push_back(mk(0, 0, 0, 0,             0, 0, 0, 1,      1, 1,  0, 0, 0,           1, RESP_OK, 32'h50, 0, 1));
        vt.push_back(mk(0, 0, 0, 0,             0, 0, 0, 0,      1, 0,  0, 0, 0,           0, 0, 0, 0,            0));

        // ---- four back-to-back ops, out-of-order responses 2,0,3,1, queue held full ----
        vt.push_back(mk(1, CMD_ADD, 32'h100, 32'h200, 0, 0, 0, 0, 1, 0, 0, 0, 0,               0, 0, 0, 0, 0));
        vt.push_back(mk(1, CMD_SUB, 32'h101, 32'h201, 0, 0, 0, 0, 0, 1, CMD_ADD, 32'h100, 0,   0, 0, 0, 0, 1));
        vt.push_back(mk(1, CMD_SUB, 32'h101, 32'h201, 0, 0, 0, 0, 1, 1, 0, 32'h200, 0,         0, 0, 0, 0, 1));
        vt.push_back(mk(1, CMD_SHL, 32'h102, 32'h202, 0, 0, 0, 0, 0, 2, CMD_SUB, 32'h101, 1,   0, 0, 0, 0, 2));
        vt.push_back(mk(1, CMD_SHL, 32'h102, 32'h202, 0, 0, 0, 0, 1, 2, 0, 32'h201, 0,         0, 0, 0, 0, 2));
        vt.push_back(mk(1, CMD_SHR, 32'h103, 32'h203, 0, 0, 0, 0, 0, 3, CMD_SHL, 32'h102, 2,   0, 0, 0, 0, 3));
        vt.push_back(mk(1, CMD_SHR, 32'h103, 32'h203, 0, 0, 0, 0, 1, 3, 0, 32'h202, 0,         0, 0, 0, 0, 3));
        vt.push_back(mk(0, 0, 0, 0, RESP_OK,  32'hA2, 2, 0,       0, 0, CMD_SHR, 32'h103, 3,   0, 0, 0, 0, 4));
        vt.push_back(mk(0, 0, 0, 0, RESP_ERR, 32'hA0, 0, 0,       0, 0, 0, 32'h203, 0,         1, RESP_OK, 32'hA2, 2, 4));
        vt.push_back(mk(0, 0, 0, 0, RESP_OK,  32'hA3, 3, 0,       0, 0, 0, 0, 0,               1, RESP_OK, 32'hA2, 2, 4));
        vt.push_back(mk(0, 0, 0, 0, RESP_OK,  32'hA1, 1, 0,       0, 0, 0, 0, 0,               1, RESP_OK, 32'hA2, 2, 4));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0,               1, RESP_OK, 32'hA2, 2, 4));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,                   0, 0, 0, 0, 0,               1, RESP_OK, 32'hA2, 2, 4));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,                   1, 2, 0, 0, 0,               1, RESP_ERR, 32'hA0, 0, 3));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,                   1, 0, 0, 0, 0,               1, RESP_OK, 32'hA3, 3, 2));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,                   1, 0, 0, 0, 0,               1, RESP_OK, 32'hA1, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 0, 0,               0, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge c_clk);
            op_valid     = vt[i].v;
            op_cmd       = vt[i].cmd;
            op_a         = vt[i].a;
            op_b         = vt[i].b;
            resp_in      = vt[i].rsp;
            resp_data_in = vt[i].rdat;
            resp_tag_in  = vt[i].rtag;
            res_ready    = vt[i].rrdy;
            #1;
            chk($sformatf("v%0d req", i), 64'({req_cmd_out, req_data_out, req_tag_out}),
                64'({vt[i].e_cmd, vt[i].e_data, vt[i].e_qtag}));
            chk($sformatf("v%0d res", i), 64'({res_valid, res_resp, res_data, res_tag}),
                64'({vt[i].e_vld, vt[i].e_resp, vt[i].e_rdat, vt[i].e_restag}));
            chk($sformatf("v%0d ctl", i), 64'({op_ready, op_tag, outstanding, spurious_err}),
                64'({vt[i].e_rdy, vt[i].e_tag, vt[i].e_out, 1'b0}));
        end

        // ---- timeout: no response, result TMO+1 edges after the accept edge ----
        @(negedge c_clk);
        op_valid = 1'b1; op_cmd = CMD_ADD; op_a = 32'h7; op_b = 32'h9;
        @(posedge c_clk);
        @(negedge c_clk);
        op_valid = 1'b0;
        n = 0;
        found = 1'b0;
        // first posedge below is accept edge + 1 (the negedge above sits between)
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge c_clk);
            #1;
            if (res_valid) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("timeout latency", 64'(n), 64'(TMO + 1));
        chk("timeout result", 64'({res_resp, res_data, res_tag}), 64'({RESP_TIMEOUT, 32'd0, 2'd0}));
        chk("timeout outstanding", 64'(outstanding), 64'(1));

        // late response for the timed-out tag is flagged and not queued
        @(negedge c_clk);
        resp_in = RESP_OK; resp_data_in = 32'h55; resp_tag_in = 2'd0;
        @(posedge c_clk);
        #1;
        chk("late resp spurious", 64'(spurious_err), 64'(1));
        @(negedge c_clk);
        resp_in = RESP_NONE;
        @(posedge c_clk);
        #1;
        chk("spurious one cycle", 64'(spurious_err), 64'(0));
        @(negedge c_clk);
        res_ready = 1'b1;
        @(negedge c_clk);
        res_ready = 1'b0;
        chk("late resp not queued", 64'({res_valid, outstanding}), 64'(0));

        // ---- response for a FREE tag ----
        resp_in = RESP_OK; resp_data_in = 32'h77; resp_tag_in = 2'd2;
        @(posedge c_clk);
        #1;
        chk("free tag spurious", 64'(spurious_err), 64'(1));
        chk("free tag not queued", 64'({res_valid, outstanding}), 64'(0));
        @(negedge c_clk);
        resp_in = RESP_NONE;

        // ---- reset asserted during SEND2 ----
        op_valid = 1'b1; op_cmd = CMD_SUB; op_a = 32'h11; op_b = 32'h22;
        @(posedge c_clk);
        @(negedge c_clk);
        op_valid = 1'b0;
        @(posedge c_clk);
        #1;
        chk("send2 before reset", 64'({req_cmd_out, req_data_out, req_tag_out}), 64'({4'd0, 32'h22, 2'd0}));
        #2 reset = 1'b1;
        #1;
        chk("mid reset req", 64'({req_cmd_out, req_data_out, req_tag_out}), 64'(0));
        chk("mid reset ctl", 64'({op_ready, outstanding, res_valid}), 64'(0));
        @(negedge c_clk);
        reset = 1'b0;
        resp_in = RESP_OK; resp_data_in = 32'h33; resp_tag_in = 2'd0;
        @(posedge c_clk);
        #1;
        chk("abandoned resp spurious", 64'({spurious_err, res_valid}), 64'(2'b10));
        @(negedge c_clk);
        resp_in = RESP_NONE;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
